// File: rtl/hdlc_tx_framer.sv
// rtl/hdlc_tx_framer.sv - bit-serial HDLC transmit framer with zero insertion and abort
// Optional CRC-16-CCITT frame check sequence generation when TX_FCS_EN is defined.
module hdlc_tx_framer #(
   parameter int MAX_BYTES = 128,
   parameter int IDLE_MIN  = 8
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Tx_Enable,
   input  logic       Tx_AbortFrame,
   input  logic [7:0] Tx_Data,
   input  logic       Tx_DataValid,
   input  logic       Tx_LastByte,
   output logic       Tx_DataReady,
   output logic       Tx,
   output logic       Tx_ValidFrame,
   output logic       Tx_Done,
   output logic       Tx_AbortedTrans,
   output logic [7:0] Tx_FrameSize
);
   localparam int IW = $clog2(IDLE_MIN + 1);
   localparam logic [7:0] FLAG = 8'h7E;

   typedef enum logic [2:0] {S_IDLE, S_OPEN, S_DATA, S_FCS, S_CLOSE, S_ABORT} state_t;

   state_t        state;
   logic [4:0]    bit_cnt;
   logic [7:0]    shifter;
   logic          cur_last;
   logic [7:0]    byte_reg;
   logic          byte_full;
   logic          byte_last;
   logic          last_acc;
   logic [2:0]    ones_cnt;
   logic [IW-1:0] idle_cnt;
   logic [7:0]    frame_size;
   logic          tx_r;
   logic          vf_r;
   logic          done_r;
   logic          abrt_r;

   logic          accept;
   logic          full_now;
   logic [7:0]    nxt_data;
   logic          nxt_last;
   logic          stuff;
   logic          cur_bit;
   logic [2:0]    ones_nxt;
   logic [4:0]    seg_end;
   logic          end_now;
   logic          active;
   logic          abort_req;

`ifdef TX_FCS_EN
   logic [15:0] crc;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return (c[0] ^ b) ? ({1'b0, c[15:1]} ^ 16'h8408) : {1'b0, c[15:1]};
   endfunction
`endif

   assign Tx_DataReady    = vf_r && !byte_full && !last_acc && (state != S_ABORT);
   assign Tx              = tx_r;
   assign Tx_ValidFrame   = vf_r;
   assign Tx_Done         = done_r;
   assign Tx_AbortedTrans = abrt_r;
   assign Tx_FrameSize    = frame_size;

   // end_now marks the segment boundary, deferred by one cycle when a stuffed 0 is still owed
   always_comb begin
      accept    = Tx_DataValid && Tx_DataReady;
      full_now  = byte_full || accept;
      nxt_data  = byte_full ? byte_reg : Tx_Data;
      nxt_last  = byte_full ? byte_last : Tx_LastByte;
      stuff     = (ones_cnt == 3'd5);
      seg_end   = 5'd7;
      cur_bit   = shifter[bit_cnt[2:0]];
`ifdef TX_FCS_EN
      if (state == S_FCS) begin
         seg_end = 5'd15;
         cur_bit = ~crc[bit_cnt[3:0]];
      end
`endif
      ones_nxt  = cur_bit ? ones_cnt + 3'd1 : 3'd0;
      end_now   = stuff ? (bit_cnt == seg_end + 5'd1)
                        : (bit_cnt == seg_end && ones_nxt != 3'd5);
      active    = state inside {S_OPEN, S_DATA, S_FCS, S_CLOSE};
      abort_req = Tx_AbortFrame && active && !(state == S_CLOSE && bit_cnt == 5'd7);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         shifter    <= '0;
         cur_last   <= 1'b0;
         byte_reg   <= '0;
         byte_full  <= 1'b0;
         byte_last  <= 1'b0;
         last_acc   <= 1'b0;
         ones_cnt   <= '0;
         idle_cnt   <= IW'(IDLE_MIN);
         frame_size <= '0;
         tx_r       <= 1'b1;
         vf_r       <= 1'b0;
         done_r     <= 1'b0;
         abrt_r     <= 1'b0;
`ifdef TX_FCS_EN
         crc        <= 16'hFFFF;
`endif
      end else begin
         done_r <= 1'b0;
         abrt_r <= 1'b0;
         if (accept) begin
            byte_reg  <= Tx_Data;
            byte_last <= Tx_LastByte;
            byte_full <= 1'b1;
            if (Tx_LastByte)
               last_acc <= 1'b1;
         end
         // The abort request emits the leading 0 of the abort pattern itself
         if (abort_req) begin
            state     <= S_ABORT;
            bit_cnt   <= 5'd1;
            tx_r      <= 1'b0;
            vf_r      <= 1'b0;
            ones_cnt  <= '0;
            byte_full <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  tx_r <= 1'b1;
                  vf_r <= 1'b0;
                  if (idle_cnt < IW'(IDLE_MIN))
                     idle_cnt <= idle_cnt + 1'b1;
                  if (Tx_Enable && idle_cnt >= IW'(IDLE_MIN)) begin
                     state      <= S_OPEN;
                     bit_cnt    <= '0;
                     frame_size <= '0;
                     last_acc   <= 1'b0;
                     byte_full  <= 1'b0;
`ifdef TX_FCS_EN
                     crc        <= 16'hFFFF;
`endif
                  end
               end
               S_OPEN: begin
                  tx_r     <= FLAG[bit_cnt[2:0]];
                  vf_r     <= 1'b1;
                  ones_cnt <= '0;
                  bit_cnt  <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     bit_cnt   <= '0;
                     byte_full <= 1'b0;
                     if (full_now) begin
                        state      <= S_DATA;
                        shifter    <= nxt_data;
                        cur_last   <= nxt_last;
                        frame_size <= frame_size + 8'd1;
                     end else begin
                        state <= S_ABORT;
                     end
                  end
               end
               S_DATA, S_FCS: begin
                  vf_r <= 1'b1;
                  if (stuff) begin
                     tx_r     <= 1'b0;
                     ones_cnt <= '0;
                  end else begin
                     tx_r     <= cur_bit;
                     ones_cnt <= ones_nxt;
                     bit_cnt  <= bit_cnt + 5'd1;
`ifdef TX_FCS_EN
                     if (state == S_DATA)
                        crc <= crc_step(crc, cur_bit);
`endif
                  end
                  if (end_now) begin
                     bit_cnt <= '0;
                     if (state == S_FCS) begin
                        state <= S_CLOSE;
                     end else if (cur_last) begin
`ifdef TX_FCS_EN
                        state <= S_FCS;
`else
                        state <= S_CLOSE;
`endif
                     end else if (frame_size != 8'(MAX_BYTES) && full_now) begin
                        shifter    <= nxt_data;
                        cur_last   <= nxt_last;
                        byte_full  <= 1'b0;
                        frame_size <= frame_size + 8'd1;
                     end else begin
                        state     <= S_ABORT;
                        byte_full <= 1'b0;
                     end
                  end
               end
               S_CLOSE: begin
                  tx_r     <= FLAG[bit_cnt[2:0]];
                  vf_r     <= 1'b1;
                  ones_cnt <= '0;
                  bit_cnt  <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     done_r   <= 1'b1;
                     state    <= S_IDLE;
                     bit_cnt  <= '0;
                     idle_cnt <= '0;
                  end
               end
               S_ABORT: begin
                  tx_r     <= (bit_cnt != 5'd0);
                  vf_r     <= 1'b0;
                  ones_cnt <= '0;
                  bit_cnt  <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     abrt_r   <= 1'b1;
                     state    <= S_IDLE;
                     bit_cnt  <= '0;
                     idle_cnt <= '0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb/tb_hdlc_tx_framer.sv - directed self-checking bench for hdlc_tx_framer
module tb_hdlc_tx_framer;
   logic       Clk = 1'b0;
   logic       Rst;
   logic       Tx_Enable;
   logic       Tx_AbortFrame;
   logic [7:0] Tx_Data;
   logic       Tx_DataValid;
   logic       Tx_LastByte;
   logic       Tx_DataReady;
   logic       Tx;
   logic       Tx_ValidFrame;
   logic       Tx_Done;
   logic       Tx_AbortedTrans;
   logic [7:0] Tx_FrameSize;

   int errors = 0;
   int checks = 0;

   logic [7:0] pay [0:15];
   int avail, pidx, last_idx;
   bit took;
   logic cap [0:127];
   int cap_len, done_cnt, abrt_cnt, done_pos;

   hdlc_tx_framer dut (
      .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame),
      .Tx_Data(Tx_Data), .Tx_DataValid(Tx_DataValid), .Tx_LastByte(Tx_LastByte),
      .Tx_DataReady(Tx_DataReady), .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame),
      .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans), .Tx_FrameSize(Tx_FrameSize)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the falling edge, then present the byte source for the next rising edge
   task automatic step();
      @(negedge Clk);
      if (took) pidx++;
      if (Tx_ValidFrame && cap_len < 128) begin
         cap[cap_len] = Tx;
         cap_len++;
      end
      if (Tx_Done) begin
         done_cnt++;
         done_pos = cap_len;
      end
      if (Tx_AbortedTrans) abrt_cnt++;
      Tx_DataValid = (pidx < avail);
      Tx_Data      = (pidx < 16) ? pay[pidx] : 8'h00;
      Tx_LastByte  = (pidx == last_idx);
      took         = Tx_DataValid && Tx_DataReady;
   endtask

   function automatic logic [63:0] seq(input int start, input int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++)
         v = {v[62:0], (start + i >= 0 && start + i < 128) ? cap[start + i] : 1'bx};
      return v;
   endfunction

   task automatic clear_frame();
      cap_len = 0; done_cnt = 0; abrt_cnt = 0; done_pos = -1; pidx = 0; took = 0;
   endtask

   task automatic run_frame(input string tag);
      clear_frame();
      Tx_Enable = 1'b1;
      for (int i = 0; i < 150; i++) begin
         step();
         if (Tx_ValidFrame) Tx_Enable = 1'b0;
         if (done_cnt + abrt_cnt > 0) break;
      end
      Tx_Enable = 1'b0;
      chk({tag, "_ended"}, 64'(done_cnt + abrt_cnt > 0), 64'd1);
   endtask

   initial begin
      Rst = 1'b1; Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0;
      Tx_Data = 8'h00; Tx_DataValid = 1'b0; Tx_LastByte = 1'b0;
      avail = 0; last_idx = 99;
      for (int i = 0; i < 16; i++) pay[i] = 8'h00;
      clear_frame();
      repeat (3) step();
      chk("reset_outputs", {Tx, Tx_ValidFrame, Tx_DataReady, Tx_Done, Tx_AbortedTrans, Tx_FrameSize},
          {5'b10000, 8'h00});
      Rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_line", {Tx, Tx_ValidFrame, Tx_DataReady}, 3'b100);
      end

      pay[0] = 8'h55; avail = 1; last_idx = 0;
      run_frame("f55");
      chk("f55_open",  seq(0, 8), 8'b01111110);
      chk("f55_data",  seq(8, 8), 8'b10101010);
      chk("f55_close", seq(cap_len - 8, 8), 8'b01111110);
`ifndef TX_FCS_EN
      chk("f55_len", 64'(cap_len), 64'd24);
`endif
      chk("f55_done_pos", 64'(done_pos), 64'(cap_len));
      chk("f55_counts", {32'(done_cnt), 32'(abrt_cnt)}, {32'd1, 32'd0});
      chk("f55_size", 64'(Tx_FrameSize), 64'd1);

      pay[0] = 8'h1F; pay[1] = 8'h00; avail = 2; last_idx = 1;
      run_frame("f1f00");
      chk("f1f00_data",  seq(8, 17), 17'b11111000000000000);
      chk("f1f00_close", seq(cap_len - 8, 8), 8'b01111110);
`ifndef TX_FCS_EN
      chk("f1f00_len", 64'(cap_len), 64'd33);
`endif
      chk("f1f00_size", 64'(Tx_FrameSize), 64'd2);

      pay[0] = 8'hFF; avail = 1; last_idx = 0;
      run_frame("fff");
      chk("fff_data",  seq(8, 9), 9'b111110111);
      chk("fff_close", seq(cap_len - 8, 8), 8'b01111110);
`ifndef TX_FCS_EN
      chk("fff_len", 64'(cap_len), 64'd25);
`endif
      chk("fff_done", 64'(done_cnt), 64'd1);

      begin : abort_req_test
         logic [7:0] obs;
         logic vf_seen, ab8;
         int w;
         pay[0] = 8'h55; pay[1] = 8'h33; avail = 2; last_idx = 1;
         clear_frame();
         Tx_Enable = 1'b1;
         for (int i = 0; i < 60 && cap_len < 11; i++) begin
            step();
            if (Tx_ValidFrame) Tx_Enable = 1'b0;
         end
         Tx_Enable = 1'b0;
         chk("abort_reach", 64'(cap_len), 64'd11);
         Tx_AbortFrame = 1'b1;
         obs = '0; vf_seen = 1'b0; ab8 = 1'b0;
         for (int i = 0; i < 8; i++) begin
            step();
            Tx_AbortFrame = 1'b0;
            obs = {obs[6:0], Tx};
            vf_seen = vf_seen | Tx_ValidFrame;
            if (i == 7) ab8 = Tx_AbortedTrans;
         end
         chk("abort_pattern", obs, 8'b01111111);
         chk("abort_vf_low", 64'(vf_seen), 64'd0);
         chk("abort_pulse_8th", 64'(ab8), 64'd1);
         chk("abort_counts", {32'(done_cnt), 32'(abrt_cnt)}, {32'd0, 32'd1});
         chk("abort_frame_bits", 64'(cap_len), 64'd11);
         Tx_Enable = 1'b1;
         w = 0;
         for (int i = 0; i < 40; i++) begin
            step();
            w++;
            if (Tx_ValidFrame) break;
         end
         Tx_Enable = 1'b0;
         chk("abort_idle_gap", 64'(w), 64'd10);
         Rst = 1'b1;
         step();
         step();
         chk("midframe_reset",
             {Tx, Tx_ValidFrame, Tx_DataReady, Tx_Done, Tx_AbortedTrans, Tx_FrameSize},
             {5'b10000, 8'h00});
         Rst = 1'b0;
      end

      pay[0] = 8'hA5; avail = 1; last_idx = 99;
      run_frame("underrun");
      chk("underrun_open", seq(0, 8), 8'b01111110);
      chk("underrun_data", seq(8, 8), 8'b10100101);
      chk("underrun_bits", 64'(cap_len), 64'd16);
      chk("underrun_counts", {32'(done_cnt), 32'(abrt_cnt)}, {32'd0, 32'd1});
      chk("underrun_size", 64'(Tx_FrameSize), 64'd1);

`ifdef TX_FCS_EN
      pay[0] = 8'h01; avail = 1; last_idx = 0;
      run_frame("fcs01");
      chk("fcs01_data", seq(8, 8), 8'b10000000);
      chk("fcs01_fcs",  seq(16, 17), 17'b10001111100000111);
      chk("fcs01_close", seq(33, 8), 8'b01111110);
      chk("fcs01_len", 64'(cap_len), 64'd41);
`endif

      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
Bit-serial HDLC transmit framer, the transmit-side counterpart of the Rx receive path. It pulls bytes over a valid/ready handshake and drives the serial line `Tx` at one bit per `Clk`. Each frame is: opening flag 0x7E, zero-stuffed payload (plus FCS when enabled), closing flag. Between frames it drives idle ones, and it emits the abort pattern on request or on error.

Parameters:
- MAX_BYTES, 128, max payload bytes per frame; exceeding it aborts the frame.
- IDLE_MIN, 8, min idle-ones cycles after any frame or abort before a new frame may start.

Ports:
- Clk, input, 1, clock.
- Rst, input, 1, synchronous active-high reset.
- Tx_Enable, input, 1, start-frame request, sampled in IDLE only.
- Tx_AbortFrame, input, 1, abort request during an active frame.
- Tx_Data, input, 8, payload byte.
- Tx_DataValid, input, 1, Tx_Data valid.
- Tx_LastByte, input, 1, qualifies the accepted byte as the last of the frame.
- Tx_DataReady, output, 1, framer can accept a byte (byte register empty).
- Tx, output, 1, serial line, registered.
- Tx_ValidFrame, output, 1, high from first opening-flag bit to last closing-flag bit.
- Tx_Done, output, 1, one-cycle pulse on the last closing-flag bit.
- Tx_AbortedTrans, output, 1, one-cycle pulse on the last abort-pattern bit.
- Tx_FrameSize, output, 8, payload bytes sent in the current/last frame.

Behaviour:
- Reset (sync, active-high, wins over everything, also mid-frame):
  - Tx=1, Tx_ValidFrame=0, Tx_DataReady=0, Tx_Done=0, Tx_AbortedTrans=0, Tx_FrameSize=0.
  - State = IDLE, idle counter saturated (immediate start allowed), byte register empty.
- Bit order: LSB first for data and FCS; one bit per cycle.
- Handshake: byte accepted in any cycle with Tx_DataValid && Tx_DataReady. Tx_DataReady=1 whenever ValidFrame=1, the byte register is empty, and the last byte has not yet been accepted.
- States:
  - IDLE: Tx=1; idle counter increments (saturating). Tx_Enable && counter>=IDLE_MIN → OPEN; Tx_FrameSize cleared.
  - OPEN: 8 cycles of 0,1,1,1,1,1,1,0. After the 8th bit: byte register full → DATA; otherwise ABORT (underrun).
  - DATA:
    - Shift 8 bits of the loaded byte; Tx_FrameSize increments on load.
    - At a byte boundary: last byte → FCS (if enabled) else CLOSE.
    - Register full → next byte with no gap.
    - Empty → ABORT (underrun).
    - FrameSize==MAX_BYTES with a non-last byte pending → ABORT.
  - FCS: 16 FCS bits, then CLOSE.
  - CLOSE: 8 flag bits; Tx_Done on the 8th bit; → IDLE with idle counter=0.
  - ABORT: emit 0 then seven 1s (8 cycles); Tx_ValidFrame=0 throughout; Tx_AbortedTrans on the 8th bit; → IDLE with counter=0. Any unsent byte is discarded.
- Zero insertion:
  - Ones counter runs over DATA and FCS bits only; it is cleared in OPEN, CLOSE and ABORT.
  - After 5 consecutive 1s, the next cycle emits an inserted 0 and the shifter stalls one cycle.
  - A stuffed 0 due after the final data/FCS bit is still emitted, before the closing flag.
- Tx_AbortFrame:
  - Sampled high in OPEN, DATA, FCS or CLOSE → ABORT starts the next cycle.
  - Ignored in IDLE and ABORT.
  - Simultaneous with the last closing-flag bit: the frame completes normally (Tx_Done) and the abort is ignored.

Optional Feature:
- TX_FCS_EN defined:
  - CRC-16-CCITT (x^16+x^12+x^5+1), init 0xFFFF, updated on each unstuffed payload bit.
  - The ones-complement is sent LSB first in the FCS state.
- TX_FCS_EN undefined: FCS state and CRC logic absent; CLOSE follows the last data bit (or trailing stuffed 0) directly.

Test Plan:
- Idle after reset, no Tx_Enable for 20 cycles → Tx=1, Tx_ValidFrame=0, Tx_DataReady=0 every cycle.
- Frame of one byte 0x55 (last), FCS off → Tx = 01111110, 10101010, 01111110; Tx_Done at cycle 24 of frame; Tx_FrameSize=1.
- Byte 0x1F then 0x00 (last) → after the opening flag, Tx = 1,1,1,1,1,0(stuffed),0,0,0, then 8 zeros, then flag; data section 17 cycles.
- Byte 0xFF (last) → Tx = 1,1,1,1,1,0,1,1,1, then flag; no sixth consecutive 1 outside flags.
- Tx_AbortFrame pulsed in the 3rd data bit → next 8 Tx bits 0,1111111; Tx_AbortedTrans pulses on the 8th; Tx_ValidFrame low; no Tx_Done; new Tx_Enable is ignored until 8 idle cycles have elapsed.
- Tx_DataValid withheld after the first byte 0xA5 (not last) → ABORT at the byte boundary, Tx_AbortedTrans=1 once; with TX_FCS_EN, payload 0x01 → FCS bits on Tx match the CRC-16-CCITT reference model.
